// File: rtl/seg_display_writer.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_writer
// Purpose  : Converts a 24-bit value (hex or double-dabble decimal) to
//            seven-segment codes and writes them to the display registers.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    input  logic [23:0] value,
    input  logic        mode,
    input  logic        blank_lz,
    input  logic [5:0]  dp,
    output logic        ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data,
    output logic        done,
    output logic        ovf
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_conv  = 2'd1;
    localparam logic [1:0]  c_st_write = 2'd2;
    localparam logic [23:0] c_dec_max  = 24'd999999;
    localparam logic [4:0]  c_conv_last = 5'd19;
    localparam logic [2:0]  c_last_digit = 3'd5;

    logic [1:0]  r_state;
    logic [23:0] r_value;
    logic        r_mode;
    logic        r_blank_lz;
    logic [5:0]  r_dp;
    logic        r_ovf_flag;
    logic [23:0] r_bcd;
    logic [19:0] r_bin;
    logic [4:0]  r_cnt;
    logic [2:0]  r_idx;
    logic        r_done;
    logic        r_ovf;

    logic [23:0] w_adj;
    logic [23:0] w_src;
    logic [5:0]  w_nz;
    logic [6:0]  w_tail_nz;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic [7:0]  w_code;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 8'h3F;
            4'h1: seg7 = 8'h06;
            4'h2: seg7 = 8'h5B;
            4'h3: seg7 = 8'h4F;
            4'h4: seg7 = 8'h66;
            4'h5: seg7 = 8'h6D;
            4'h6: seg7 = 8'h7D;
            4'h7: seg7 = 8'h07;
            4'h8: seg7 = 8'h7F;
            4'h9: seg7 = 8'h6F;
            4'hA: seg7 = 8'h77;
            4'hB: seg7 = 8'h7C;
            4'hC: seg7 = 8'h39;
            4'hD: seg7 = 8'h5E;
            4'hE: seg7 = 8'h79;
            default: seg7 = 8'h71;
        endcase
    endfunction

    assign w_src = r_mode ? r_bcd : r_value;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                      r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
            assign w_nz[gi] = |w_src[4*gi +: 4];
            // w_tail_nz[i]: some digit at position i or above is non-zero
            assign w_tail_nz[gi] = w_nz[gi] | w_tail_nz[gi+1];
        end
    endgenerate
    assign w_tail_nz[6] = 1'b0;

    assign w_digit = w_src[{r_idx, 2'b00} +: 4];
    assign w_blank = r_blank_lz && !w_tail_nz[r_idx] && (r_idx != 3'd0);
    assign w_code  = r_ovf_flag ? 8'h40 :
                     ((w_blank ? 8'h00 : seg7(w_digit)) | {r_dp[r_idx], 7'd0});

    assign ready    = (r_state == c_st_idle);
    assign bus_we   = (r_state == c_st_write);
    assign bus_addr = bus_we ? BASE_ADDR + {27'd0, r_idx, 2'b00} : 32'd0;
    assign bus_data = bus_we ? {24'd0, w_code} : 32'd0;
    assign done     = r_done;
    assign ovf      = r_ovf;

    always_ff @(posedge clk) begin
        if (res) begin
            r_state    <= c_st_idle;
            r_value    <= 24'd0;
            r_mode     <= 1'b0;
            r_blank_lz <= 1'b0;
            r_dp       <= 6'd0;
            r_ovf_flag <= 1'b0;
            r_bcd      <= 24'd0;
            r_bin      <= 20'd0;
            r_cnt      <= 5'd0;
            r_idx      <= 3'd0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_value    <= value;
                        r_mode     <= mode;
                        r_blank_lz <= blank_lz;
                        r_dp       <= dp;
                        r_bcd      <= 24'd0;
                        r_bin      <= value[19:0];
                        r_cnt      <= 5'd0;
                        r_idx      <= 3'd0;
                        r_ovf_flag <= mode && (value > c_dec_max);
                        r_state    <= (mode && (value <= c_dec_max)) ?
                                      c_st_conv : c_st_write;
                    end
                end
                c_st_conv: begin
                    r_bcd <= {w_adj[22:0], r_bin[19]};
                    r_bin <= {r_bin[18:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_conv_last) begin
                        r_state <= c_st_write;
                    end
                end
                c_st_write: begin
                    r_idx <= r_idx + 3'd1;
                    if (r_idx == c_last_digit) begin
                        r_state <= c_st_idle;
                        r_done  <= 1'b1;
                        r_ovf   <= r_ovf_flag;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_writer
// Purpose  : Directed self-checking bench for seg_display_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_writer;

    localparam logic [31:0] BASE_ADDR = 32'h0000_0010;

    logic        clk;
    logic        res;
    logic        start;
    logic [23:0] value;
    logic        mode;
    logic        blank_lz;
    logic [5:0]  dp;
    logic        ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_data;
    logic        done;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    seg_display_writer #(.BASE_ADDR(BASE_ADDR)) u_dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .value    (value),
        .mode     (mode),
        .blank_lz (blank_lz),
        .dp       (dp),
        .ready    (ready),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .done     (done),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [23:0] v, input logic m, input logic b, input logic [5:0] d);
        start    = 1'b1;
        value    = v;
        mode     = m;
        blank_lz = b;
        dp       = d;
        chk("ready_before_start", {31'd0, ready}, 32'd1);
        tick;
        start = 1'b0;
    endtask

    // codes: digit i expected at codes[8i +: 8]
    task automatic expect_writes(input string tag, input logic [47:0] codes);
        for (int i = 0; i < 6; i++) begin
            chk({tag, "_we"},   {31'd0, bus_we}, 32'd1);
            chk({tag, "_addr"}, bus_addr, BASE_ADDR + 32'(4 * i));
            chk({tag, "_data"}, bus_data, {24'd0, codes[8*i +: 8]});
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
            tick;
        end
    endtask

    task automatic expect_done(input string tag, input logic exp_ovf);
        chk({tag, "_done"},  {31'd0, done},   32'd1);
        chk({tag, "_ovf"},   {31'd0, ovf},    {31'd0, exp_ovf});
        chk({tag, "_ready"}, {31'd0, ready},  32'd1);
        chk({tag, "_we_off"}, {31'd0, bus_we}, 32'd0);
        tick;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic expect_conv(input string tag);
        for (int i = 0; i < 20; i++) begin
            chk({tag, "_conv_we"},    {31'd0, bus_we}, 32'd0);
            chk({tag, "_conv_ready"}, {31'd0, ready},  32'd0);
            tick;
        end
    endtask

    initial begin
        int done_seen;
        res      = 1'b1;
        start    = 1'b0;
        value    = 24'd0;
        mode     = 1'b0;
        blank_lz = 1'b0;
        dp       = 6'd0;
        tick;
        tick;
        chk("rst_ready", {31'd0, ready},  32'd1);
        chk("rst_we",    {31'd0, bus_we}, 32'd0);
        chk("rst_addr",  bus_addr, 32'd0);
        chk("rst_data",  bus_data, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf},  32'd0);
        res = 1'b0;
        tick;

        // Hex 12AB3F
        launch(24'h12AB3F, 1'b0, 1'b0, 6'd0);
        chk("hex_ready_busy", {31'd0, ready}, 32'd0);
        expect_writes("hex", {8'h06, 8'h5B, 8'h77, 8'h7C, 8'h4F, 8'h71});
        expect_done("hex", 1'b0);

        // Decimal 123456
        launch(24'd123456, 1'b1, 1'b0, 6'd0);
        expect_conv("dec");
        expect_writes("dec", {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D});
        expect_done("dec", 1'b0);

        // Decimal 42 with blanking and dp on digit 0
        launch(24'd42, 1'b1, 1'b1, 6'b000001);
        expect_conv("blank42");
        expect_writes("blank42", {8'h00, 8'h00, 8'h00, 8'h00, 8'h66, 8'hDB});
        expect_done("blank42", 1'b0);

        // Hex zero with blanking: digit 0 stays visible
        launch(24'd0, 1'b0, 1'b1, 6'd0);
        expect_writes("blank0", {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F});
        expect_done("blank0", 1'b0);

        // Decimal overflow: dashes, dp ignored
        launch(24'd1000000, 1'b1, 1'b0, 6'h3F);
        expect_writes("ovf", {6{8'h40}});
        expect_done("ovf", 1'b1);

        // start held high, value changed mid-run, back-to-back accept on done
        start    = 1'b1;
        value    = 24'h654321;
        mode     = 1'b0;
        blank_lz = 1'b0;
        dp       = 6'd0;
        tick;
        value = 24'h0000A0;
        chk("hs_ready_busy", {31'd0, ready}, 32'd0);
        expect_writes("hs_first", {8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06});
        chk("hs_done",  {31'd0, done},  32'd1);
        chk("hs_ready", {31'd0, ready}, 32'd1);
        tick;
        start = 1'b0;
        expect_writes("hs_second", {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h77, 8'h3F});
        expect_done("hs_second", 1'b0);

        // Reset during the third write cycle
        launch(24'h12AB3F, 1'b0, 1'b0, 6'd0);
        tick;
        tick;
        chk("rstw_third_we",   {31'd0, bus_we}, 32'd1);
        chk("rstw_third_addr", bus_addr, BASE_ADDR + 32'd8);
        res = 1'b1;
        tick;
        res = 1'b0;
        chk("rstw_we",    {31'd0, bus_we}, 32'd0);
        chk("rstw_addr",  bus_addr, 32'd0);
        chk("rstw_data",  bus_data, 32'd0);
        chk("rstw_done",  {31'd0, done}, 32'd0);
        chk("rstw_ready", {31'd0, ready}, 32'd1);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || bus_we) done_seen++;
            tick;
        end
        chk("rstw_quiet", 32'(done_seen), 32'd0);
        launch(24'hFEDCBA, 1'b0, 1'b0, 6'b100000);
        expect_writes("post_rst", {8'hF1, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77});
        expect_done("post_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_writer.md
# seg_display_writer

Bus-master front end for the six-digit seven-segment display peripheral. Accepts a 24-bit value through a start/ready handshake and converts it to segment codes, either as hex digits or as decimal digits via an iterative double-dabble conversion. It then issues six single-cycle register writes into the display peripheral's SEG0..SEG5 registers. It sits directly upstream of the display peripheral, driving its `we`/`addr`/`dataIn` inputs.

## Interface
- `BASE_ADDR`, default 32'h0000_0010: address of SEG0. Digit i is written to BASE_ADDR + 4*i.
- `clk` input 1: single clock; all logic on the rising edge.
- `res` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only while `ready`=1.
- `value` input 24: number to display; latched on an accepted start.
- `mode` input 1: 0 = hex (six nibbles), 1 = decimal (0..999999); latched on an accepted start.
- `blank_lz` input 1: 1 = blank leading zero digits; latched on an accepted start.
- `dp` input 6: dp[i]=1 sets bit 7 of digit i; latched on an accepted start.
- `ready` output 1: high in IDLE only.
- `bus_we` output 1: write strobe to the peripheral.
- `bus_addr` output 32: write address.
- `bus_data` output 32: write data, {24'd0, code}.
- `done` output 1: one-cycle completion pulse.
- `ovf` output 1: one-cycle pulse with `done` when a decimal value exceeded 999999.

## Operation
- States: IDLE, CONV, WRITE. Reset forces IDLE.
- **IDLE:** `ready`=1. On `start`=1, latch `value`, `mode`, `blank_lz` and `dp`, then:
  - hex → WRITE;
  - decimal with value <= 999999 → CONV;
  - decimal with value > 999999 → WRITE with the overflow flag set.
- **CONV:** exactly 20 cycles of double-dabble on value[19:0] into a 24-bit BCD register. Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. After the 20th cycle → WRITE.
- **WRITE:** 6 cycles, digit index i = 0..5, least significant digit first.
  - Each cycle: `bus_we`=1, `bus_addr`=BASE_ADDR+4*i, `bus_data`[7:0]=code(i).
  - After i=5 → IDLE.
- Digit source: hex uses value[4i+3:4i]; decimal uses BCD nibble i.
- Segment code: bit0=a … bit6=g, bit7=dp, active-high (the peripheral inverts).
  - Codes, 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Leading-zero blanking (`blank_lz`=1, either mode): digit i is blank (0x00) when digits i..5 are all zero and i != 0. Digit 0 is never blanked.
- `dp[i]` is ORed into digit i, including blanked digits.
- Overflow: all six digits are written as 0x40 ("-"). `dp` and `blank_lz` are ignored.
- Ignored inputs:
  - `start` is ignored outside IDLE.
  - Inputs are not re-sampled mid-operation, so a changed `value` has no effect until the next accepted start.
- Bus idle rule: `bus_we`=0 implies `bus_addr`=0 and `bus_data`=0.
- Reset mid-operation (any state): aborts immediately to IDLE. No further writes, no `done`, no `ovf`.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- After any cycle with `res`=1: `ready`=1, `bus_we`=0, `bus_addr`=0, `bus_data`=0, `done`=0, `ovf`=0.
- Start accepted at edge T:
  - hex/overflow: writes in cycles T+1..T+6; `done` (and `ovf` if overflow) in cycle T+7.
  - decimal: CONV in cycles T+1..T+20, writes in T+21..T+26, `done` in T+27.
- `ready`=1 in the same cycle as `done`. A `start` in that cycle is accepted (back-to-back); the next write follows at T'+1.
- Exactly six `bus_we` pulses per accepted start, on consecutive cycles, with ascending addresses.

## Test plan
- Hex: value=24'h12AB3F, mode=0, blank_lz=0, dp=0 → writes 0x10:71, 0x14:4F, 0x18:7C, 0x1C:77, 0x20:5B, 0x24:06; `done` at T+7.
- Decimal: value=123456, mode=1 → 20 idle bus cycles, then writes 7D, 6D, 66, 4F, 5B, 06 at 0x10..0x24; `done` at T+27; `ovf`=0.
- Blanking and dp: value=42, mode=1, blank_lz=1, dp=6'b000001 → DB, 66, 00, 00, 00, 00. Then value=0, mode=0, blank_lz=1, dp=0 → 3F, 00, 00, 00, 00, 00.
- Overflow: value=1000000, mode=1, dp=6'h3F → six writes of 0x40 at T+1..T+6; `done`=`ovf`=1 at T+7.
- Handshake: `start` held high throughout a hex operation with `value` changed mid-run → no second latch until the `done` cycle. Second operation's first write occurs at T+8; original data written unchanged.
- Reset mid-write: assert `res` during the 3rd write cycle → `bus_we`=0 from the next cycle, no `done`, `ready`=1. A new start then completes normally.
